// File: rtl/aoi2_pkg.sv
// Shared definitions for the AOI2 sweep checker and the AOI bench scoreboard.
package aoi2_pkg;

    localparam int VEC_W       = 4;
    localparam int NUM_VECTORS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } aoi2_chk_state_t;

    // Reference AND-OR-INVERT function; vector index is {a,b,c,d}, d is the LSB.
    function automatic logic aoi2_golden(logic [3:0] v);
        return ~((v[3] & v[2]) | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/aoi2_sweep_ctr.sv
// Sweep counters: vector index, pass index and settle down-counter.
module aoi2_sweep_ctr
    import aoi2_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             init,
    input  logic             advance,
    input  logic             tick,
    output logic [VEC_W-1:0] vector,
    output logic             settle_done,
    output logic             last_vector
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_PASS   = 4'(NUM_PASSES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    logic [3:0] pass_idx;
    logic [7:0] settle_cnt;

    // Counter update: clear beats init beats advance beats settle tick.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector     <= '0;
            pass_idx   <= '0;
            settle_cnt <= '0;
        end else if (clear) begin
            vector     <= '0;
            pass_idx   <= '0;
            settle_cnt <= '0;
        end else if (init) begin
            vector     <= '0;
            pass_idx   <= '0;
            settle_cnt <= SETTLE_LOAD;
        end else if (advance) begin
            vector     <= vector + VEC_W'(1);
            settle_cnt <= SETTLE_LOAD;
            if (vector == LAST_VEC) begin
                pass_idx <= pass_idx + 4'd1;
            end
        end else if (tick && settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

    // Settle window ends on the edge that sees the counter at zero.
    assign settle_done = (settle_cnt == 8'd0);
    assign last_vector = (vector == LAST_VEC) && (pass_idx == LAST_PASS);

endmodule

// File: rtl/aoi2_sweep_checker.sv
// Exhaustive stimulus driver and response checker for a 4-input AOI cell.
module aoi2_sweep_checker
    import aoi2_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             g_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    aoi2_chk_state_t  state, state_next;
    logic [VEC_W-1:0] vector;
    logic             settle_done;
    logic             last_vector;
    logic             run_start;
    logic             ctr_clear;
    logic             ctr_advance;
    logic             ctr_tick;
    logic             mismatch;

    // Abort overrides everything, including a start on the same edge.
    assign run_start   = (state == ST_IDLE) && start && !abort;
    assign ctr_clear   = abort || (state == ST_DONE);
    assign ctr_advance = (state == ST_SAMPLE) && !last_vector && !abort;
    assign ctr_tick    = (state == ST_SETTLE) && !abort;
    assign mismatch    = (state == ST_SAMPLE) && (g_in != aoi2_golden(vector));

    aoi2_sweep_ctr #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .NUM_PASSES    (NUM_PASSES)
    ) u_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (ctr_clear),
        .init        (run_start),
        .advance     (ctr_advance),
        .tick        (ctr_tick),
        .vector      (vector),
        .settle_done (settle_done),
        .last_vector (last_vector)
    );

    // Stimulus comes straight from the registered vector index.
    assign {a, b, c, d} = vector;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front guarantees state_next is written
    // on every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (start) state_next = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_next = ST_SAMPLE;
                ST_SAMPLE: state_next = last_vector ? ST_DONE : ST_SETTLE;
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
        done = (state == ST_DONE);
    end

    // Result registers: cleared on start, updated on each sample edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (abort) begin
            pass <= 1'b0;
        end else if (run_start) begin
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (state == ST_SAMPLE) begin
            if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!first_err_valid) begin
                    first_err_vec   <= vector;
                    first_err_valid <= 1'b1;
                end
            end
            // The final sample's own result must count towards pass.
            if (last_vector) begin
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: doc/aoi2_sweep_checker.md
Name: aoi2_sweep_checker

Overview:
Sequential stimulus driver and response checker for the team's 4-input AND-OR-INVERT cell (g = ~((a&b)|(c&d))).
- Drives all 16 input combinations into an external AOI instance and samples its output g after a programmable settle time.
- Compares each sample against the golden function and reports pass/fail, error count and first failing vector.
- Sits at the opposite end of the AOI interface: it drives the inputs the cell consumes and consumes the output the cell drives. Used for on-chip self-test and as a reusable bench component.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.
- NUM_PASSES, 1, full 16-vector sweeps per run; legal range 1..15.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  starts a run; sampled only in IDLE.
- abort  in  1  synchronous abort; any state returns to IDLE.
- g_in  in  1  output of the AOI under check.
- a, b, c, d  out  1 each  registered stimulus; vector index = {a,b,c,d}, d is the LSB.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last completed run had zero errors; held until the next start.
- err_count  out  ERR_W  mismatches in the last run; saturates at all-ones.
- first_err_vec  out  4  vector index of the first mismatch.
- first_err_valid  out  1  high when first_err_vec holds a valid index.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including a..d, pass and err_count.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Edge with start=1 and abort=0: clear err_count, pass and first_err_valid; set vector=0 and pass_idx=0; busy=1; go to SETTLE.
- SETTLE:
  - Hold a..d for SETTLE_CYCLES edges using a down-counter, then go to SAMPLE.
- SAMPLE (one edge):
  - Compare g_in against golden(vector).
  - On mismatch: increment err_count, saturating. If first_err_valid=0, latch first_err_vec=vector and set first_err_valid=1.
  - If vector=15 and pass_idx=NUM_PASSES-1: go to DONE.
  - Else: vector=vector+1, wrapping 15->0 and incrementing pass_idx; go to SETTLE.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0). Go to IDLE on the next edge.
- Latency: done pulses on the edge 16*NUM_PASSES*(SETTLE_CYCLES+1)+1 counted from the start edge. With defaults this is edge 49.
- Abort:
  - Abort=1 in any state: next edge goes to IDLE with busy=0 and a..d=0. done is not pulsed.
  - pass and err_count keep their partial values but are invalid; pass is forced to 0.
  - Abort has priority over start on the same edge.
- start while busy is ignored and never queued.
- Reset mid-run: immediate return to the reset state. No done pulse.
- g_in is used only on the SAMPLE edge; it is a don't-care in every other state.
- err_count arithmetic is unsigned and saturating, never wrapping.

Decomposition:
- Package aoi2_pkg contains:
  - state enum aoi2_chk_state_t
  - VEC_W=4 and NUM_VECTORS=16
  - function aoi2_golden(logic [3:0] v) returning ~((v[3]&v[2])|(v[1]&v[0])), shared with the AOI bench scoreboard.
- Sub-module aoi2_sweep_ctr holds the vector index, pass index and settle down-counter, and outputs a last_vector flag. The FSM and result registers stay in the top.

Test Plan:
1. Correct AOI on g_in, defaults, start pulse -> done on edge 49; pass=1; err_count=0; first_err_valid=0; a..d visit 0..15 in ascending order.
2. g_in stuck at 1 -> err_count=7; first_err_vec=4'b0011; pass=0.
3. g_in stuck at 0, NUM_PASSES=2 -> err_count=18; first_err_vec=4'b0000; done on edge 97.
4. g_in = OR without invert -> err_count=16; first_err_vec=0. With ERR_W=4: err_count saturates at 15.
5. abort asserted on edge 20 -> busy=0 and a..d=0 next cycle, no done pulse; a following start gives a clean result as in test 1.
6. start re-pulsed mid-run -> ignored, done still on edge 49. rst_n low mid-run -> all outputs 0 immediately, and the next start runs normally.
